// File: rtl/bp_ras_pkg.sv
// bp_ras_pkg: register struct, reset constant and pointer-step helper for bp_ras.
package bp_ras_pkg;
  import river_cfg_pkg::*;
  localparam int RAS_ABITS_DEF = CFG_CPU_ADDR_BITS;
  localparam int RAS_DEPTH_LOG2_DEF = 3;
  localparam int RAS_LOG2_MAX = 6;
  localparam int RAS_SPW = RAS_LOG2_MAX;
  localparam int RAS_CNTW = RAS_LOG2_MAX + 1;
  typedef struct packed {
    logic [RAS_SPW-1:0]  sp;
    logic [RAS_CNTW-1:0] cnt;
    logic [RAS_SPW-1:0]  csp;
    logic [RAS_CNTW-1:0] ccnt;
  } bp_ras_registers;
  typedef struct packed {
    logic [RAS_SPW-1:0]  sp;
    logic [RAS_CNTW-1:0] cnt;
  } bp_ras_ptr_t;
  localparam bp_ras_registers bp_ras_r_reset = '0;
  // Pointers stay masked to the configured depth, so upper bits are always zero.
  function automatic bp_ras_ptr_t ras_next(logic [RAS_SPW-1:0] sp, logic [RAS_CNTW-1:0] cnt,
                                           logic push, logic pop, int depth_log2);
    logic [RAS_SPW-1:0]  mask;
    logic [RAS_CNTW-1:0] full;
    logic                rep;
    bp_ras_ptr_t         n;
    mask = RAS_SPW'((1 << depth_log2) - 1);
    full = RAS_CNTW'(1 << depth_log2);
    rep = push && pop && cnt != '0;
    n.sp = rep ? sp : push ? (sp + 1'b1) & mask : (pop && cnt != '0) ? (sp - 1'b1) & mask : sp;
    n.cnt = rep ? cnt : push ? ((cnt == full) ? full : cnt + 1'b1) : (pop && cnt != '0) ? cnt - 1'b1 : cnt;
    return n;
  endfunction
endpackage

// File: rtl/river_cfg_pkg.sv
// river_cfg_pkg: core-wide configuration constants shared by River blocks.
package river_cfg_pkg;
  localparam int CFG_CPU_ADDR_BITS = 64;
endpackage

// File: rtl/bp_ras.sv
// bp_ras: return-address stack with speculative and committed pointers.
// BP_RAS_CHECKPOINT_EN: flush restores committed pointers instead of clearing the stack.
module bp_ras
  import bp_ras_pkg::*;
#(
  parameter int abits      = RAS_ABITS_DEF,
  parameter int depth_log2 = RAS_DEPTH_LOG2_DEF
) (
  input  logic             i_clk,
  input  logic             i_nrst,
  input  logic             i_push,
  input  logic [abits-1:0] i_push_addr,
  input  logic             i_pop,
  input  logic             i_commit_push,
  input  logic             i_commit_pop,
  input  logic             i_flush,
  output logic             o_ret_valid,
  output logic [abits-1:0] o_ret_addr
);
  localparam int DEPTH = 1 << depth_log2;
  bp_ras_registers  r_q, r_d;
  bp_ras_ptr_t      spec_n, com_n;
  logic [abits-1:0] mem_q [DEPTH];
  logic [abits-1:0] top;
  always_comb begin
    spec_n = ras_next(r_q.sp, r_q.cnt, i_push, i_pop, depth_log2);
    com_n = ras_next(r_q.csp, r_q.ccnt, i_commit_push, i_commit_pop, depth_log2);
    r_d = r_q;
`ifdef BP_RAS_CHECKPOINT_EN
    r_d.csp = com_n.sp;
    r_d.ccnt = com_n.cnt;
    r_d.sp = i_flush ? com_n.sp : spec_n.sp;
    r_d.cnt = i_flush ? com_n.cnt : spec_n.cnt;
`else
    r_d.sp = i_flush ? '0 : spec_n.sp;
    r_d.cnt = i_flush ? '0 : spec_n.cnt;
`endif
  end
  always_comb begin
    top = '0;
    for (int i = 0; i < DEPTH; i++) if (r_q.sp == RAS_SPW'(i)) top = mem_q[i];
  end
  // A push always lands at the new top: sp+1 for a plain push, sp for pop+push.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_q <= bp_ras_r_reset;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      r_q <= r_d;
      for (int i = 0; i < DEPTH; i++)
        if (i_push && !i_flush && spec_n.sp == RAS_SPW'(i)) mem_q[i] <= i_push_addr;
    end
  end
  assign o_ret_valid = r_q.cnt != '0;
  assign o_ret_addr  = top;
endmodule
